bitrev_reorder_pingpong: RTL and testbench
==========================================

# bitrev_reorder_pingpong

Parametrised, streaming bit-reversal reorder buffer for the FFT back end. It accepts one frame of `N_POINTS` complex samples (I/Q), `LANES` samples per beat, in the FFT's bit-reversed output order, and re-emits the frame in natural or descending bin order, `LANES` samples per beat. It sits between the last CBFP stage and the output sink. Two ping-pong banks and valid/ready handshakes on both sides let the next frame load while the current one drains.

## Interface
- `DATA_W`, 13: signed sample width, I and Q each.
- `N_POINTS`, 512: frame length; power of two, ≥ 4.
- `LANES`, 32: samples per beat on both sides; power of two, 2 ≤ `LANES` ≤ `N_POINTS`/2.
- `OUT_DESCEND`, 1: 0 = output position p holds bin p; 1 = output position p holds bin `N_POINTS`-1-p.
- Derived: `BEATS` = `N_POINTS`/`LANES`; `LOG2N` = log2(`N_POINTS`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous flush; same end state as reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: buffer can accept a beat.
- `in_i` / `in_q` input `LANES`×`DATA_W` signed: lane k of input beat b is memory slot b·`LANES`+k.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: sink accepts the beat.
- `out_i` / `out_q` output `LANES`×`DATA_W` signed: reordered lanes.
- `out_first` / `out_last` output 1: qualify the first and last beat of a frame; meaningful only when `out_valid` = 1.
- `frame_done` output 1: one-cycle pulse on the handshake of the last output beat.

## Operation
- Each bank is `N_POINTS` × 2·`DATA_W`. Each bank has state EMPTY → FILLING → FULL → DRAINING → EMPTY.
- **Write side**
  - Pointer `wr_bank` and beat counter `wcnt` (0..`BEATS`-1).
  - Input handshake = `in_valid` && `in_ready`. On it, write all lanes to `wr_bank` at slots `wcnt`·`LANES`+k and increment `wcnt`.
  - The first beat moves EMPTY→FILLING.
  - The beat with `wcnt` = `BEATS`-1 moves the bank to FULL, wraps `wcnt` to 0 and toggles `wr_bank`.
  - `in_ready` = state[`wr_bank`] ∈ {EMPTY, FILLING}.
- **Read side**
  - Pointer `rd_bank` and beat counter `rcnt`.
  - When state[`rd_bank`] = FULL, the bank moves to DRAINING and beats are emitted.
  - Output beat r, lane k, has position p = r·`LANES`+k and carries slot bitrev_LOG2N(p), or bitrev_LOG2N(`N_POINTS`-1-p) when `OUT_DESCEND` = 1.
  - Output handshake = `out_valid` && `out_ready`. On it, `rcnt` increments.
  - On the handshake of beat `BEATS`-1: the bank moves to EMPTY, `rcnt` wraps to 0, `rd_bank` toggles, and `frame_done` pulses.
- Banks are consumed strictly in fill order. A frame is never emitted before all of its beats are written.
- Data passes through unmodified: no rounding, saturation or sign change.
- **Simultaneous events**
  - A bank released by the last output handshake at edge t is seen EMPTY from t+1. `in_ready` for that bank rises after t+1, not combinationally.
  - Write and read in the same cycle on different banks are always permitted.
  - Both banks FULL or DRAINING means `in_ready` = 0. The upstream stalls and no data is lost.
- **`clr` / `rst`** (mid-frame included)
  - All banks go EMPTY; `wcnt`, `rcnt`, `wr_bank` and `rd_bank` go to 0.
  - `out_valid` goes to 0; partial and unread frames are discarded.
  - `clr` has priority over a same-cycle handshake on either side. That beat is dropped.

## Timing
- Reset values: `in_ready` = 1 (combinational from EMPTY state), `out_valid` = 0, `out_first` = 0, `out_last` = 0, `frame_done` = 0, `out_i` = `out_q` = 0.
- **Output register**
  - `out_*` are registered.
  - `out_valid` rises at edge t+1 after the last input handshake of a frame at edge t, when the read side is idle.
  - Latency from the last input beat to the first output beat is 1 cycle.
- **Stall**
  - While `out_valid` && !`out_ready`, `out_i`, `out_q`, `out_first` and `out_last` hold stable.
  - `out_valid` never drops without a handshake, except on `clr`/`rst`.
- **Throughput**
  - With `out_ready` held at 1, beats go out back-to-back: one frame every `BEATS` cycles.
  - Input is continuously accepted, except for at most one bubble per frame at the bank hand-off.
- `frame_done` is asserted in the cycle after the last output handshake edge and lasts exactly one cycle.

## Test plan
- **Default parameters, natural order**
  - Stimulus: `OUT_DESCEND` = 0, 512/32; one frame with `in_i` = slot index, `in_q` = −slot index.
  - Required: 16 beats; beat 0 lanes 0..3 = 0, 256, 128, 384; beat 15 lane 31 = 511; `out_first` on beat 0, `out_last` on beat 15, one `frame_done` pulse.
- **Descending**
  - Stimulus: `OUT_DESCEND` = 1, same frame.
  - Required: beat 0 lane 0 = 511, lane 1 = 255; beat 15 lane 31 = 0.
- **Small configuration**
  - Stimulus: `N_POINTS` = 16, `LANES` = 4, `OUT_DESCEND` = 0; ramp input.
  - Required: beats {0,8,4,12}, {2,10,6,14}, {1,9,5,13}, {3,11,7,15}.
- **Back-pressure**
  - Stimulus: 3 back-to-back frames, `out_ready` held low 40 cycles.
  - Required: `in_ready` drops after 2 frames; outputs hold stable; all 3 frames are emitted intact and in order after release.
- **Random `out_ready` (50%), continuous input**
  - Required: every frame matches the reference model with zero lost or duplicated beats.
- **Flush mid-frame**
  - Stimulus: `clr` after 7 input beats with frame 1 DRAINING.
  - Required: next cycle `out_valid` = 0, `in_ready` = 1; a fresh frame then emerges correctly. `rst` asserted asynchronously mid-frame gives the same result.

Source files
------------

// File: rtl/bitrev_reorder_pingpong.sv
// Streaming bit-reversal reorder buffer: two ping-pong banks load a frame in FFT
// bit-reversed order while the other bank drains it in natural or descending bin order.
module bitrev_reorder_pingpong #(
  parameter int unsigned DATA_W      = 13,
  parameter int unsigned N_POINTS    = 512,
  parameter int unsigned LANES       = 32,
  parameter int unsigned OUT_DESCEND = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [LANES-1:0][DATA_W-1:0]   in_i,
  input  logic signed [LANES-1:0][DATA_W-1:0]   in_q,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [LANES-1:0][DATA_W-1:0]   out_i,
  output logic signed [LANES-1:0][DATA_W-1:0]   out_q,
  output logic                                  out_first,
  output logic                                  out_last,
  output logic                                  frame_done
);

  localparam int unsigned BEATS  = N_POINTS / LANES;
  localparam int unsigned LOG2N  = $clog2(N_POINTS);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned SAMP_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_FULL     = 2'd2,
    S_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t                        r_state [2];
  logic                               r_wr_bank;
  logic                               r_rd_bank;
  logic [BEAT_W-1:0]                  r_wcnt;
  logic [BEAT_W-1:0]                  r_rcnt;
  logic                               r_out_valid;
  logic                               r_out_first;
  logic                               r_out_last;
  logic                               r_frame_done;
  logic [LANES-1:0][DATA_W-1:0]       r_out_i;
  logic [LANES-1:0][DATA_W-1:0]       r_out_q;
  logic [SAMP_W-1:0]                  r_mem [2][N_POINTS];

  bank_state_t                        w_state_nxt [2];
  logic                               w_wr_bank_nxt;
  logic                               w_rd_bank_nxt;
  logic [BEAT_W-1:0]                  w_wcnt_nxt;
  logic [BEAT_W-1:0]                  w_rcnt_nxt;
  logic                               w_valid_nxt;
  logic                               w_first_nxt;
  logic                               w_last_nxt;
  logic                               w_done_nxt;
  logic                               w_load;
  logic                               w_load_bank;
  logic [BEAT_W-1:0]                  w_load_beat;
  logic                               w_in_hs;
  logic                               w_out_hs;
  logic                               w_wr_en;
  logic [LOG2N-1:0]                   w_slot [LANES];

  // Memory slot read by output lane 'lane' of beat 'beat'.
  function automatic logic [LOG2N-1:0] f_slot(input logic [BEAT_W-1:0] beat,
                                              input logic [LANE_W-1:0] lane);
    logic [LOG2N-1:0] pos;
    pos = {beat, lane};
    if (OUT_DESCEND != 0) pos = ~pos;
    f_slot = '0;
    for (int unsigned i = 0; i < LOG2N; i++) f_slot[i] = pos[LOG2N-1-i];
  endfunction

  assign in_ready   = (r_state[r_wr_bank] == S_EMPTY) || (r_state[r_wr_bank] == S_FILLING);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_wr_en    = w_in_hs && !clr;

  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign out_i      = r_out_i;
  assign out_q      = r_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0]   <= S_EMPTY;
      r_state[1]   <= S_EMPTY;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state[0]   <= w_state_nxt[0];
      r_state[1]   <= w_state_nxt[1];
      r_wr_bank    <= w_wr_bank_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_out_valid  <= w_valid_nxt;
      r_out_first  <= w_first_nxt;
      r_out_last   <= w_last_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  // Bank state machines, write/read pointers and output-register control.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    w_wr_bank_nxt  = r_wr_bank;
    w_rd_bank_nxt  = r_rd_bank;
    w_wcnt_nxt     = r_wcnt;
    w_rcnt_nxt     = r_rcnt;
    w_valid_nxt    = r_out_valid;
    w_first_nxt    = r_out_first;
    w_last_nxt     = r_out_last;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_load_bank    = r_rd_bank;
    w_load_beat    = '0;

    if (clr) begin
      w_state_nxt[0] = S_EMPTY;
      w_state_nxt[1] = S_EMPTY;
      w_wr_bank_nxt  = 1'b0;
      w_rd_bank_nxt  = 1'b0;
      w_wcnt_nxt     = '0;
      w_rcnt_nxt     = '0;
      w_valid_nxt    = 1'b0;
      w_first_nxt    = 1'b0;
      w_last_nxt     = 1'b0;
    end else begin
      if (w_in_hs) begin
        if (r_wcnt == BEAT_W'(BEATS - 1)) begin
          w_state_nxt[r_wr_bank] = S_FULL;
          w_wcnt_nxt             = '0;
          w_wr_bank_nxt          = ~r_wr_bank;
        end else begin
          w_state_nxt[r_wr_bank] = S_FILLING;
          w_wcnt_nxt             = r_wcnt + BEAT_W'(1);
        end
      end

      if (w_out_hs) begin
        if (r_rcnt == BEAT_W'(BEATS - 1)) begin
          w_state_nxt[r_rd_bank] = S_EMPTY;
          w_rcnt_nxt             = '0;
          w_rd_bank_nxt          = ~r_rd_bank;
          w_done_nxt             = 1'b1;
          // Chain straight into the other bank when it is already complete.
          if (r_state[~r_rd_bank] == S_FULL) begin
            w_state_nxt[~r_rd_bank] = S_DRAINING;
            w_load                  = 1'b1;
            w_load_bank             = ~r_rd_bank;
            w_first_nxt             = 1'b1;
            w_last_nxt              = 1'b0;
          end else begin
            w_valid_nxt = 1'b0;
            w_first_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end else begin
          w_rcnt_nxt  = r_rcnt + BEAT_W'(1);
          w_load      = 1'b1;
          w_load_beat = r_rcnt + BEAT_W'(1);
          w_first_nxt = 1'b0;
          w_last_nxt  = (r_rcnt + BEAT_W'(1)) == BEAT_W'(BEATS - 1);
        end
      end else if (!r_out_valid && (r_state[r_rd_bank] == S_FULL)) begin
        w_state_nxt[r_rd_bank] = S_DRAINING;
        w_load                 = 1'b1;
        w_valid_nxt            = 1'b1;
        w_first_nxt            = 1'b1;
        w_last_nxt             = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) w_slot[k] = f_slot(w_load_beat, LANE_W'(k));
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned k = 0; k < LANES; k++)
        r_mem[r_wr_bank][{r_wcnt, LANE_W'(k)}] <= {in_i[k], in_q[k]};
    end
  end

  // Output data register: loads only when a new beat is presented, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_i <= '0;
      r_out_q <= '0;
    end else if (clr) begin
      r_out_i <= '0;
      r_out_q <= '0;
    end else if (w_load) begin
      for (int unsigned k = 0; k < LANES; k++)
        {r_out_i[k], r_out_q[k]} <= r_mem[w_load_bank][w_slot[k]];
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_pingpong.sv
// Directed bench for bitrev_reorder_pingpong: natural, descending and 16/4 instances
// checked against hand-computed values and a bit-reversal reference.
module tb_bitrev_reorder_pingpong;

  localparam int DW = 13;
  localparam int N  = 512;
  localparam int L  = 32;
  localparam int B  = N / L;
  localparam int SL = 4;
  localparam int W  = L * DW;

  logic clk = 1'b0;
  logic rst, clr, in_valid, out_ready;
  logic signed [L-1:0][DW-1:0] in_i, in_q, out_i, out_q, d_out_i, d_out_q;
  logic in_ready, out_valid, out_first, out_last, frame_done;
  logic d_in_ready, d_out_valid, d_out_first, d_out_last, d_frame_done;
  logic s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_first, s_last, s_done;
  logic signed [SL-1:0][DW-1:0] s_in_i, s_in_q, s_out_i, s_out_q;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  bit hand = 1'b0;
  int s_exp [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  bitrev_reorder_pingpong #(.DATA_W(DW), .N_POINTS(N), .LANES(L), .OUT_DESCEND(0)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q), .out_first(out_first), .out_last(out_last),
    .frame_done(frame_done));

  bitrev_reorder_pingpong #(.DATA_W(DW), .N_POINTS(N), .LANES(L), .OUT_DESCEND(1)) u_dut_d (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_i(d_out_i), .out_q(d_out_q), .out_first(d_out_first), .out_last(d_out_last),
    .frame_done(d_frame_done));

  bitrev_reorder_pingpong #(.DATA_W(DW), .N_POINTS(16), .LANES(SL), .OUT_DESCEND(0)) u_dut_s (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_i(s_in_i), .in_q(s_in_q), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_i(s_out_i), .out_q(s_out_q), .out_first(s_first), .out_last(s_last),
    .frame_done(s_done));

  always @(negedge clk) if (frame_done === 1'b1) n_done++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int f_rev9(input int p);
    int r;
    r = 0;
    for (int i = 0; i < 9; i++) r = r | (((p >> i) & 1) << (8 - i));
    return r;
  endfunction

  task automatic set_beat(input int tag, input int b);
    for (int k = 0; k < L; k++) begin
      in_i[k] = DW'(tag * N + b * L + k);
      in_q[k] = DW'(-(tag * N + b * L + k));
    end
  endtask

  task automatic send_beats(input int tag, input int nb);
    bit acc;
    int cyc;
    for (int b = 0; b < nb; b++) begin
      set_beat(tag, b);
      in_valid = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        cyc++;
      end while (!acc && cyc < 2000);
      if (!acc) begin
        chk("send_stall", acc, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_beat(input int tag, input int r);
    logic [L-1:0][DW-1:0] ei, eq, di, dq;
    int p, v, vd;
    for (int k = 0; k < L; k++) begin
      p = r * L + k;
      v = tag * N + f_rev9(p);
      vd = tag * N + f_rev9(N - 1 - p);
      ei[k] = DW'(v);
      eq[k] = DW'(-v);
      di[k] = DW'(vd);
      dq[k] = DW'(-vd);
    end
    chk("out_i", out_i, ei);
    chk("out_q", out_q, eq);
    chk("out_first", out_first, r == 0);
    chk("out_last", out_last, r == B - 1);
    chk("d_valid", d_out_valid, 1'b1);
    chk("d_out_i", d_out_i, di);
    chk("d_out_q", d_out_q, dq);
    if (hand && r == B - 1) begin
      chk("nat_b15_l31", out_i[31], 511);
      chk("desc_b15_l31", d_out_i[31], 0);
    end
  endtask

  task automatic recv_frames(input int nf, input int tag0, input int mode);
    int r, cyc, t0;
    bit last_hs;
    r = 0; cyc = 0; t0 = 0; last_hs = 1'b0;
    while (r < nf * B && cyc < 3000) begin
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (last_hs) chk("frame_done", frame_done, 1'b1);
      last_hs = 1'b0;
      if (out_valid && out_ready) begin
        check_beat(tag0 + r / B, r % B);
        if (r % B == 0) t0 = cyc;
        if (r % B == B - 1) begin
          last_hs = 1'b1;
          if (mode == 0) chk("back_to_back", cyc - t0, B - 1);
        end
        r++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (r != nf * B) chk("recv_count", r, nf * B);
    if (last_hs) begin
      @(negedge clk);
      chk("frame_done", frame_done, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n0;
    logic [W-1:0] snap_i, snap_q;
    logic [SL-1:0][DW-1:0] se;
    int cyc;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_i = '0; in_q = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_i = '0; s_in_q = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_out_i", out_i, '0);
    chk("rst_s_in_ready", s_in_ready, 1'b1);
    @(posedge clk); #1;

    // Natural and descending order, single frame with one-cycle latency.
    hand = 1'b1;
    n0 = n_done;
    send_beats(0, B);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("nat_b0_l0", out_i[0], 0);
    chk("nat_b0_l1", out_i[1], 256);
    chk("nat_b0_l2", out_i[2], 128);
    chk("nat_b0_l3", out_i[3], 384);
    chk("nat_b0_first", out_first, 1'b1);
    chk("nat_b0_last", out_last, 1'b0);
    chk("desc_b0_l0", d_out_i[0], 511);
    chk("desc_b0_l1", d_out_i[1], 255);
    @(posedge clk); #1;
    recv_frames(1, 0, 0);
    hand = 1'b0;
    chk("done_count_1", n_done - n0, 1);

    // Back-pressure: three frames against a sink stalled for 40 cycles.
    n0 = n_done;
    fork
      begin
        send_beats(1, B); send_beats(2, B); send_beats(3, B);
      end
      begin
        out_ready = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        @(negedge clk);
        snap_i = out_i; snap_q = out_q;
        chk("bp_valid_early", out_valid, 1'b1);
        @(posedge clk); #1;
        repeat (19) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_valid_held", out_valid, 1'b1);
        chk("bp_i_stable", out_i, snap_i);
        chk("bp_q_stable", out_q, snap_q);
        chk("bp_first_held", out_first, 1'b1);
        @(posedge clk); #1;
        recv_frames(3, 1, 0);
      end
    join
    chk("done_count_3", n_done - n0, 3);

    // Random sink readiness with continuous input.
    n0 = n_done;
    fork
      begin
        send_beats(4, B); send_beats(5, B); send_beats(6, B); send_beats(7, B);
      end
      recv_frames(4, 4, 1);
    join
    chk("done_count_rand", n_done - n0, 4);

    // Synchronous flush mid-frame with another frame draining.
    send_beats(1, B);
    send_beats(2, 7);
    set_beat(2, 7);
    in_valid = 1'b1; out_ready = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    chk("clr_frame_done", frame_done, 1'b0);
    chk("clr_out_i", out_i, '0);
    chk("clr_d_out_valid", d_out_valid, 1'b0);
    @(posedge clk); #1;
    fork
      send_beats(3, B);
      recv_frames(1, 3, 0);
    join

    // Asynchronous reset mid-frame.
    send_beats(4, B);
    send_beats(5, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_i", out_i, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      send_beats(6, B);
      recv_frames(1, 6, 0);
    join

    // 16-point, 4-lane instance with a ramp frame.
    for (int b = 0; b < 4; b++) begin
      s_in_valid = 1'b1;
      for (int k = 0; k < SL; k++) begin
        s_in_i[k] = DW'(b * SL + k);
        s_in_q[k] = DW'(-(b * SL + k));
      end
      @(negedge clk);
      chk("s_in_ready", s_in_ready, 1'b1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cyc = 0;
      @(negedge clk);
      while (!s_out_valid && cyc < 20) begin
        @(posedge clk); #1;
        @(negedge clk);
        cyc++;
      end
      for (int k = 0; k < SL; k++) se[k] = DW'(s_exp[b * SL + k]);
      chk("s_beat", s_out_i, se);
      chk("s_first", s_first, b == 0);
      chk("s_last", s_last, b == 3);
      @(posedge clk); #1;
    end
    s_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
